// File: rtl/nios2_pll_lock_ctrl.sv
// nios2_pll_lock_ctrl
//   Power-up and recovery sequencer for the ADC PLL. Runs on the free-running
//   reference clock. It pulses the PLL reset, waits for lock with a timeout, and
//   requires lock to hold for a qualification window before it releases the
//   downstream reset. A failed attempt is retried a bounded number of times and
//   then the block parks in FAULT. Loss of lock in RUN re-sequences the PLL.
//
//   Optional feature macro: NIOS2_PLL_LOCK_CTRL_LOSS_CNT_EN
//     defined   : loss_cnt counts lock-loss events in RUN (saturating at 255)
//     undefined : loss_cnt is tied to zero
//
// Ports
//   clk         in   reference clock
//   reset_n     in   asynchronous active-low reset
//   pll_locked  in   PLL lock flag, asynchronous (2-FF synchronised here)
//   sw_restart  in   1-cycle pulse, restarts the sequence from any state
//   pll_rst     out  PLL reset, active-high
//   sys_rst_n   out  downstream reset, active-low, high only in RUN
//   fault       out  high in FAULT
//   state_o     out  current state (debug)
//   retry_cnt   out  failed attempts in the current sequence (saturates at 3)
//   loss_cnt    out  lock-loss events seen in RUN (saturates at 255)
//
// state      | meaning
// RST_PLL    | PLL reset held for RST_CYCLES
// WAIT_LOCK  | PLL released, waiting for synced lock (timeout LOCK_TIMEOUT)
// STABLE     | lock must hold STABLE_CYCLES consecutive cycles
// RUN        | qualified lock, downstream reset released
// FAULT      | retries exhausted, PLL held in reset until sw_restart/reset_n

module nios2_pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       sw_restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       fault,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Terminal counts: the timer starts at 0 on state entry, so a state that
  // must last N cycles leaves on the cycle the timer reads N-1.
  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] timer;
  logic [1:0]       lock_sync;
  logic             lock_s;
  logic             attempt_fail;
  logic             lock_loss;
  logic             timer_clr;
  logic             retry_at_max;

  assign lock_s       = lock_sync[1];
  assign state_o      = state;
  assign retry_at_max = (32'(retry_cnt) >= MAX_RETRIES);

  always_comb begin
    state_n      = state;
    attempt_fail = 1'b0;
    lock_loss    = 1'b0;
    case (state)
      ST_RST_PLL: begin
        if (timer == RST_TC) state_n = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                state_n      = ST_STABLE;
        else if (timer == LOCK_TC) attempt_fail = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s)                 attempt_fail = 1'b1;
        else if (timer == STABLE_TC) state_n      = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          lock_loss = 1'b1;
          state_n   = ST_RST_PLL;
        end
      end
      ST_FAULT: state_n = ST_FAULT;
      default:  state_n = ST_RST_PLL;
    endcase
    if (attempt_fail) state_n = retry_at_max ? ST_FAULT : ST_RST_PLL;
    // Restart overrides any same-cycle fail or loss so neither is counted.
    if (sw_restart) begin
      state_n      = ST_RST_PLL;
      attempt_fail = 1'b0;
      lock_loss    = 1'b0;
    end
  end

  // A restart while already in RST_PLL must still restart the reset count.
  assign timer_clr = sw_restart || (state_n != state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync <= 2'b00;
      state     <= ST_RST_PLL;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
      state     <= state_n;
      if (timer_clr)       timer <= '0;
      else if (timer != '1) timer <= timer + CNT_W'(1);
      // Outputs decode the next state so they change together with state_o.
      pll_rst   <= (state_n == ST_RST_PLL) || (state_n == ST_FAULT);
      sys_rst_n <= (state_n == ST_RUN);
      fault     <= (state_n == ST_FAULT);
      if (sw_restart || lock_loss)
        retry_cnt <= 2'd0;
      else if (attempt_fail && !retry_at_max && retry_cnt != 2'd3)
        retry_cnt <= retry_cnt + 2'd1;
    end
  end

`ifdef NIOS2_PLL_LOCK_CTRL_LOSS_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            loss_cnt <= 8'd0;
    else if (lock_loss && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_nios2_pll_lock_ctrl.sv
// Testbench for nios2_pll_lock_ctrl. Expected behaviour is derived from event
// times: each scenario records the clock edge at which it drives pll_locked or
// sw_restart and computes the edges at which outputs must change.
module tb_nios2_pll_lock_ctrl;

  localparam int RC = 4;
  localparam int LT = 50;
  localparam int SC = 8;
  localparam int MR = 2;

`ifdef NIOS2_PLL_LOCK_CTRL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [15:0] obs;

  int edge_n = 0;
  int n_chk = 0;
  int n_fail = 0;
  int loss_model = 0;

  nios2_pll_lock_ctrl #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .sw_restart(sw_restart),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .fault(fault), .state_o(state_o),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  assign obs = {pll_rst, sys_rst_n, fault, state_o, retry_cnt, loss_cnt};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got edge %0d want completion", edge_n);
    $fatal(1, "watchdog");
  end

  // Expected output vector {pll_rst, sys_rst_n, fault, state, retry, loss}.
  function automatic logic [15:0] ev(input logic pr, input logic sr, input logic f,
                                     input logic [2:0] st, input logic [1:0] rc,
                                     input int loss);
    ev = {pr, sr, f, st, rc, (LOSS_EN ? 8'(loss) : 8'd0)};
  endfunction

  task automatic to_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    sw_restart = 1'b0;
    loss_model = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] want;
    int base;
    do_reset();
    #1;
    want = ev(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL reset_values: got %h want %h", obs, want); end
    reset_n = 1'b1;
    base = edge_n;
    to_edge(base + RC - 1);
    want = ev(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL rst_pll_last_cycle: got %h want %h", obs, want); end
    to_edge(base + RC);
    want = ev(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL enter_wait_lock: got %h want %h", obs, want); end
  endtask

  // Continues from WAIT_LOCK entered at the current edge.
  task automatic test_powerup();
    logic [15:0] want;
    int w, d, m, s;
    w = edge_n;
    d = $urandom_range(0, 40);
    m = w + d;
    to_edge(m);
    pll_locked = 1'b1;
    s = (w + 1 > m + 3) ? w + 1 : m + 3;
    to_edge(s - 1);
    want = ev(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL powerup_pre_stable d=%0d: got %h want %h", d, obs, want); end
    to_edge(s);
    want = ev(0, 0, 0, 2, 0, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL powerup_stable d=%0d: got %h want %h", d, obs, want); end
    to_edge(s + SC - 1);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL powerup_stable_end d=%0d: got %h want %h", d, obs, want); end
    to_edge(s + SC);
    want = ev(0, 1, 0, 3, 0, 0);
    n_chk++;
    if (obs !== want || (s + SC - m) != 2 + SC + 1) begin
      n_fail++; $display("FAIL powerup_run d=%0d: got %h want %h", d, obs, want);
    end
  endtask

  task automatic test_run_loss();
    logic [15:0] want;
    int l, r, w, m, s;
    for (int it = 0; it < 3; it++) begin
      l = edge_n;
      pll_locked = 1'b0;
      r = $urandom_range(0, 20);
      to_edge(l + 2);
      want = ev(0, 1, 0, 3, 0, loss_model);
      n_chk++;
      if (obs !== want) begin n_fail++; $display("FAIL loss_still_run it=%0d: got %h want %h", it, obs, want); end
      to_edge(l + 3);
      loss_model++;
      want = ev(1, 0, 0, 0, 0, loss_model);
      n_chk++;
      if (obs !== want) begin n_fail++; $display("FAIL loss_reset it=%0d: got %h want %h", it, obs, want); end
      w = l + 3 + RC;
      m = l + 3 + r;
      to_edge(m);
      pll_locked = 1'b1;
      s = (w + 1 > m + 3) ? w + 1 : m + 3;
      to_edge(s - 1);
      want = ev(0, 0, 0, 1, 0, loss_model);
      n_chk++;
      if (obs !== want) begin n_fail++; $display("FAIL reseq_wait it=%0d: got %h want %h", it, obs, want); end
      to_edge(s + SC - 1);
      want = ev(0, 0, 0, 2, 0, loss_model);
      n_chk++;
      if (obs !== want) begin n_fail++; $display("FAIL reseq_stable it=%0d: got %h want %h", it, obs, want); end
      to_edge(s + SC);
      want = ev(0, 1, 0, 3, 0, loss_model);
      n_chk++;
      if (obs !== want) begin n_fail++; $display("FAIL reseq_run it=%0d: got %h want %h", it, obs, want); end
    end
  endtask

  // Starts from RUN with a restart that also drops lock; lock then never returns.
  task automatic test_no_lock();
    logic [15:0] want;
    int p, base, per, chunk, pos;
    per = RC + LT;
    p = edge_n;
    pll_locked = 1'b0;
    sw_restart = 1'b1;
    to_edge(p + 1);
    sw_restart = 1'b0;
    base = p + 1;
    for (int n = 0; n <= (MR + 1) * per + 5; n++) begin
      to_edge(base + n);
      chunk = n / per;
      pos   = n % per;
      if (chunk <= MR) want = ev(pos < RC, 0, 0, (pos < RC) ? 3'd0 : 3'd1, 2'(chunk), loss_model);
      else             want = ev(1, 0, 1, 3'd4, 2'(MR), loss_model);
      n_chk++;
      if (obs !== want) begin n_fail++; $display("FAIL no_lock n=%0d: got %h want %h", n, obs, want); end
    end
  endtask

  // Starts in FAULT.
  task automatic test_sw_restart();
    logic [15:0] want;
    int p, w, r0;
    p = edge_n;
    sw_restart = 1'b1;
    to_edge(p + 1);
    sw_restart = 1'b0;
    want = ev(1, 0, 0, 0, 0, loss_model);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL restart_from_fault: got %h want %h", obs, want); end
    w = p + 1 + RC;
    to_edge(w + LT - 1);
    want = ev(0, 0, 0, 1, 0, loss_model);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL restart_wait: got %h want %h", obs, want); end
    sw_restart = 1'b1;
    to_edge(w + LT);
    sw_restart = 1'b0;
    want = ev(1, 0, 0, 0, 0, loss_model);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL restart_vs_timeout: got %h want %h", obs, want); end
    to_edge(w + LT + 2);
    sw_restart = 1'b1;
    to_edge(w + LT + 3);
    sw_restart = 1'b0;
    r0 = w + LT + 3;
    to_edge(r0 + RC - 1);
    want = ev(1, 0, 0, 0, 0, loss_model);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL restart_in_rst_pll: got %h want %h", obs, want); end
    to_edge(r0 + RC);
    want = ev(0, 0, 0, 1, 0, loss_model);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL restart_rst_len: got %h want %h", obs, want); end
  endtask

  task automatic test_glitch();
    logic [15:0] want;
    int base, w, d, m, g, f, w2, s;
    do_reset();
    reset_n = 1'b1;
    base = edge_n;
    w = base + RC;
    d = $urandom_range(0, 30);
    g = $urandom_range(1, SC);
    m = w + d;
    to_edge(m);
    pll_locked = 1'b1;
    to_edge(m + g);
    pll_locked = 1'b0;
    to_edge(m + g + 1);
    pll_locked = 1'b1;
    f = m + g + 3;
    to_edge(f - 1);
    want = ev(0, 0, 0, 2, 0, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL glitch_pre g=%0d: got %h want %h", g, obs, want); end
    to_edge(f);
    want = ev(1, 0, 0, 0, 1, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL glitch_fail g=%0d: got %h want %h", g, obs, want); end
    w2 = f + RC;
    s = w2 + 1;
    to_edge(w2);
    want = ev(0, 0, 0, 1, 1, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL glitch_retry_wait: got %h want %h", obs, want); end
    to_edge(s + SC - 1);
    want = ev(0, 0, 0, 2, 1, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL glitch_retry_stable: got %h want %h", obs, want); end
    to_edge(s + SC);
    want = ev(0, 1, 0, 3, 1, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL glitch_retry_run: got %h want %h", obs, want); end
  endtask

  // Starts in RUN: one lock loss, then asynchronous reset in STABLE.
  task automatic test_async_reset();
    logic [15:0] want;
    int l, s, k;
    l = edge_n;
    pll_locked = 1'b0;
    to_edge(l + 3);
    loss_model++;
    want = ev(1, 0, 0, 0, 0, loss_model);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL async_pre_loss: got %h want %h", obs, want); end
    pll_locked = 1'b1;
    s = l + 3 + RC + 1;
    k = $urandom_range(1, SC - 1);
    to_edge(s + k);
    want = ev(0, 0, 0, 2, 0, loss_model);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL async_in_stable: got %h want %h", obs, want); end
    #3;
    reset_n = 1'b0;
    #1;
    want = ev(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (obs !== want) begin n_fail++; $display("FAIL async_reset_values: got %h want %h", obs, want); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    sw_restart = 1'b0;
    test_reset();
    test_powerup();
    test_run_loss();
    test_no_lock();
    test_sw_restart();
    test_glitch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
